// File: rtl/pipeline_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl_if
// Purpose  : Handshake bundle between pipeline memory channels and the
//            stall controller.
// Revision : 1.0
// ============================================================================
interface pipeline_stall_ctrl_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] resp;
    logic                 flush;
    logic                 advance;
    logic [NUM_PORTS-1:0] resp_ok;
    logic [NUM_PORTS-1:0] wait_vec;
    logic [1:0]           state;
    logic                 err;

    modport master (
        output req, resp, flush,
        input  advance, resp_ok, wait_vec, state, err
    );

    modport slave (
        input  req, resp, flush,
        output advance, resp_ok, wait_vec, state, err
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Purpose  : Per-port outstanding/stale request tracking and pipeline
//            advance/stall sequencing.
// Revision : 1.0
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipeline_stall_ctrl_if.slave  sif
);

    localparam int c_MAXO = (1 << CNT_W) - 1;
    localparam int c_SMAX = 2 * c_MAXO;
    localparam int c_SW   = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_MOVING = 2'b01,
        S_WAIT   = 2'b10,
        S_DRAIN  = 2'b11
    } state_t;

    state_t              r_state;
    logic                r_err;
    logic [CNT_W-1:0]    r_pend  [NUM_PORTS];
    logic [c_SW-1:0]     r_stale [NUM_PORTS];

    logic [CNT_W-1:0]     w_pend_nxt  [NUM_PORTS];
    logic [c_SW-1:0]      w_stale_nxt [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_resp_ok;
    logic [NUM_PORTS-1:0] w_port_clear;
    logic [NUM_PORTS-1:0] w_wait;
    logic                 w_any_pend;
    logic                 w_any_stale;
    logic                 w_err_set;
    logic                 w_advance;

    always_comb begin
        int v_pend;
        int v_tot;
        v_pend      = 0;
        v_tot       = 0;
        w_err_set   = 1'b0;
        w_any_pend  = 1'b0;
        w_any_stale = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_resp_ok[i]    = sif.resp[i] && (r_stale[i] == '0);
            w_wait[i]       = (r_pend[i] != '0);
            w_port_clear[i] = (r_pend[i] == '0) ||
                              ((r_pend[i] == CNT_W'(1)) && w_resp_ok[i]);
            w_pend_nxt[i]   = r_pend[i];
            w_stale_nxt[i]  = r_stale[i];
            if (sif.flush) begin
                // Everything live becomes stale; a same-cycle response retires one of them.
                v_tot = int'(r_stale[i]) + int'(r_pend[i]);
                if (sif.resp[i]) begin
                    if (v_tot == 0) begin
                        w_err_set = 1'b1;
                    end else begin
                        v_tot = v_tot - 1;
                    end
                end
                if (v_tot > c_SMAX) begin
                    v_tot     = c_SMAX;
                    w_err_set = 1'b1;
                end
                w_stale_nxt[i] = c_SW'(v_tot);
                w_pend_nxt[i]  = CNT_W'(sif.req[i]);
            end else begin
                if (sif.resp[i] && !w_resp_ok[i]) begin
                    w_stale_nxt[i] = r_stale[i] - c_SW'(1);
                end
                v_pend = int'(r_pend[i]) + int'(sif.req[i]);
                if (w_resp_ok[i]) begin
                    if (r_pend[i] == '0) begin
                        w_err_set = 1'b1;
                    end
                    if (v_pend > 0) begin
                        v_pend = v_pend - 1;
                    end
                end
                if (v_pend > c_MAXO) begin
                    v_pend    = c_MAXO;
                    w_err_set = 1'b1;
                end
                w_pend_nxt[i] = CNT_W'(v_pend);
            end
            if (w_pend_nxt[i] != '0) begin
                w_any_pend = 1'b1;
            end
            if (w_stale_nxt[i] != '0) begin
                w_any_stale = 1'b1;
            end
        end
    end

    // Stale traffic never holds the pipeline; only live work does.
    assign w_advance = (r_state == S_IDLE) ? 1'b0 :
                       sif.flush           ? 1'b1 : (&w_port_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_pend[i]  <= '0;
                r_stale[i] <= '0;
            end
        end else begin
            r_err <= r_err | w_err_set;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_pend[i]  <= w_pend_nxt[i];
                r_stale[i] <= w_stale_nxt[i];
            end
            if (r_state == S_IDLE) begin
                r_state <= S_MOVING;
            end else if (w_any_pend) begin
                r_state <= S_WAIT;
            end else if (w_any_stale) begin
                r_state <= S_DRAIN;
            end else begin
                r_state <= S_MOVING;
            end
        end
    end

    assign sif.advance  = w_advance;
    assign sif.resp_ok  = w_resp_ok;
    assign sif.wait_vec = w_wait;
    assign sif.state    = r_state;
    assign sif.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Purpose  : Directed self-checking bench for pipeline_stall_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipeline_stall_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipeline_stall_ctrl_if #(.NUM_PORTS(2)) bus2 ();
    pipeline_stall_ctrl_if #(.NUM_PORTS(4)) bus4 ();

    pipeline_stall_ctrl #(.NUM_PORTS(2), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .sif (bus2.slave)
    );

    pipeline_stall_ctrl #(.NUM_PORTS(4), .CNT_W(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .sif (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus2.resp = 2'b01;
        #1;
        n_checks++; if (bus2.state !== 2'b00) begin n_fail++; $display("FAIL rst_state: got %b want 00", bus2.state); end
        n_checks++; if (bus2.advance !== 1'b0) begin n_fail++; $display("FAIL rst_adv: got %b want 0", bus2.advance); end
        n_checks++; if (bus2.wait_vec !== 2'b00) begin n_fail++; $display("FAIL rst_wait: got %b want 00", bus2.wait_vec); end
        n_checks++; if (bus2.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus2.err); end
        n_checks++; if (bus2.resp_ok !== 2'b01) begin n_fail++; $display("FAIL rst_respok: got %b want 01", bus2.resp_ok); end
        bus2.resp = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus2.state !== 2'b00) begin n_fail++; $display("FAIL rel_idle: got %b want 00", bus2.state); end
        n_checks++; if (bus2.advance !== 1'b0) begin n_fail++; $display("FAIL rel_adv0: got %b want 0", bus2.advance); end
        tick();
        n_checks++; if (bus2.state !== 2'b01) begin n_fail++; $display("FAIL rel_moving: got %b want 01", bus2.state); end
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL rel_adv1: got %b want 1", bus2.advance); end
        n_checks++; if (bus4.state !== 2'b01) begin n_fail++; $display("FAIL rel_moving4: got %b want 01", bus4.state); end
    endtask

    task automatic test_stall_release();
        bus2.req = 2'b11;
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL sr_adv_issue: got %b want 1", bus2.advance); end
        tick();
        bus2.req  = 2'b00;
        n_checks++; if (bus2.state !== 2'b10) begin n_fail++; $display("FAIL sr_wait1: got %b want 10", bus2.state); end
        n_checks++; if (bus2.wait_vec !== 2'b11) begin n_fail++; $display("FAIL sr_wv1: got %b want 11", bus2.wait_vec); end
        bus2.resp = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b0) begin n_fail++; $display("FAIL sr_adv_stall: got %b want 0", bus2.advance); end
        n_checks++; if (bus2.resp_ok !== 2'b01) begin n_fail++; $display("FAIL sr_ok1: got %b want 01", bus2.resp_ok); end
        tick();
        n_checks++; if (bus2.state !== 2'b10) begin n_fail++; $display("FAIL sr_wait2: got %b want 10", bus2.state); end
        n_checks++; if (bus2.wait_vec !== 2'b10) begin n_fail++; $display("FAIL sr_wv2: got %b want 10", bus2.wait_vec); end
        bus2.resp = 2'b10;
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL sr_adv_rel: got %b want 1", bus2.advance); end
        n_checks++; if (bus2.resp_ok !== 2'b10) begin n_fail++; $display("FAIL sr_ok2: got %b want 10", bus2.resp_ok); end
        tick();
        bus2.resp = 2'b00;
        n_checks++; if (bus2.state !== 2'b01) begin n_fail++; $display("FAIL sr_moving: got %b want 01", bus2.state); end
        n_checks++; if (bus2.wait_vec !== 2'b00) begin n_fail++; $display("FAIL sr_wv3: got %b want 00", bus2.wait_vec); end
        n_checks++; if (bus2.err !== 1'b0) begin n_fail++; $display("FAIL sr_err: got %b want 0", bus2.err); end
    endtask

    task automatic test_flush();
        bus2.req = 2'b10;
        tick();
        bus2.req = 2'b00;
        n_checks++; if (bus2.wait_vec !== 2'b10) begin n_fail++; $display("FAIL fl_wv0: got %b want 10", bus2.wait_vec); end
        bus2.flush = 1'b1;
        bus2.req   = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL fl_adv: got %b want 1", bus2.advance); end
        tick();
        bus2.flush = 1'b0;
        bus2.req   = 2'b00;
        n_checks++; if (bus2.state !== 2'b10) begin n_fail++; $display("FAIL fl_wait: got %b want 10", bus2.state); end
        n_checks++; if (bus2.wait_vec !== 2'b01) begin n_fail++; $display("FAIL fl_wv1: got %b want 01", bus2.wait_vec); end
        bus2.resp = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.resp_ok !== 2'b01) begin n_fail++; $display("FAIL fl_ok_live: got %b want 01", bus2.resp_ok); end
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL fl_adv_live: got %b want 1", bus2.advance); end
        tick();
        bus2.resp = 2'b00;
        n_checks++; if (bus2.state !== 2'b11) begin n_fail++; $display("FAIL fl_drain: got %b want 11", bus2.state); end
        n_checks++; if (bus2.wait_vec !== 2'b00) begin n_fail++; $display("FAIL fl_wv2: got %b want 00", bus2.wait_vec); end
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL fl_adv_drain: got %b want 1", bus2.advance); end
        bus2.resp = 2'b10;
        #1;
        n_checks++; if (bus2.resp_ok !== 2'b00) begin n_fail++; $display("FAIL fl_ok_stale: got %b want 00", bus2.resp_ok); end
        tick();
        bus2.resp = 2'b00;
        n_checks++; if (bus2.state !== 2'b01) begin n_fail++; $display("FAIL fl_moving: got %b want 01", bus2.state); end
        n_checks++; if (bus2.err !== 1'b0) begin n_fail++; $display("FAIL fl_err: got %b want 0", bus2.err); end
    endtask

    task automatic test_same_cycle_4port();
        bus4.req = 4'b0001;
        tick();
        n_checks++; if (bus4.wait_vec !== 4'b0001) begin n_fail++; $display("FAIL p4_wv0: got %b want 0001", bus4.wait_vec); end
        bus4.resp = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus4.advance !== 1'b1) begin n_fail++; $display("FAIL p4_adv0: got %b want 1", bus4.advance); end
        n_checks++; if (bus4.resp_ok !== 4'b0001) begin n_fail++; $display("FAIL p4_ok0: got %b want 0001", bus4.resp_ok); end
        tick();
        n_checks++; if (bus4.wait_vec !== 4'b0001) begin n_fail++; $display("FAIL p4_wv1: got %b want 0001", bus4.wait_vec); end
        n_checks++; if (bus4.state !== 2'b10) begin n_fail++; $display("FAIL p4_wait: got %b want 10", bus4.state); end
        bus4.req  = 4'b0110;
        bus4.resp = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus4.advance !== 1'b1) begin n_fail++; $display("FAIL p4_adv1: got %b want 1", bus4.advance); end
        tick();
        n_checks++; if (bus4.wait_vec !== 4'b0110) begin n_fail++; $display("FAIL p4_wv2: got %b want 0110", bus4.wait_vec); end
        bus4.req  = 4'b0000;
        bus4.resp = 4'b0110;
        @(negedge clk);
        n_checks++; if (bus4.resp_ok !== 4'b0110) begin n_fail++; $display("FAIL p4_ok2: got %b want 0110", bus4.resp_ok); end
        tick();
        bus4.resp = 4'b0000;
        n_checks++; if (bus4.wait_vec !== 4'b0000) begin n_fail++; $display("FAIL p4_wv3: got %b want 0000", bus4.wait_vec); end
        n_checks++; if (bus4.state !== 2'b01) begin n_fail++; $display("FAIL p4_moving: got %b want 01", bus4.state); end
        n_checks++; if (bus4.err !== 1'b0) begin n_fail++; $display("FAIL p4_err: got %b want 0", bus4.err); end
    endtask

    task automatic test_reset_mid();
        bus2.req = 2'b11;
        tick();
        bus2.req = 2'b00;
        n_checks++; if (bus2.wait_vec !== 2'b11) begin n_fail++; $display("FAIL rm_wv_pre: got %b want 11", bus2.wait_vec); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus2.wait_vec !== 2'b00) begin n_fail++; $display("FAIL rm_wv: got %b want 00", bus2.wait_vec); end
        n_checks++; if (bus2.state !== 2'b00) begin n_fail++; $display("FAIL rm_state: got %b want 00", bus2.state); end
        n_checks++; if (bus2.advance !== 1'b0) begin n_fail++; $display("FAIL rm_adv: got %b want 0", bus2.advance); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++; if (bus2.state !== 2'b01) begin n_fail++; $display("FAIL rm_moving: got %b want 01", bus2.state); end
    endtask

    task automatic test_idle_resp();
        bus2.resp = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.resp_ok !== 2'b01) begin n_fail++; $display("FAIL ir_ok: got %b want 01", bus2.resp_ok); end
        tick();
        bus2.resp = 2'b00;
        n_checks++; if (bus2.err !== 1'b1) begin n_fail++; $display("FAIL ir_err: got %b want 1", bus2.err); end
        n_checks++; if (bus2.wait_vec !== 2'b00) begin n_fail++; $display("FAIL ir_wv: got %b want 00", bus2.wait_vec); end
        n_checks++; if (bus2.state !== 2'b01) begin n_fail++; $display("FAIL ir_state: got %b want 01", bus2.state); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        n_checks++; if (bus2.err !== 1'b0) begin n_fail++; $display("FAIL sat_err_clr: got %b want 0", bus2.err); end
        bus2.req = 2'b01;
        repeat (3) tick();
        n_checks++; if (bus2.err !== 1'b0) begin n_fail++; $display("FAIL sat_err_at3: got %b want 0", bus2.err); end
        tick();
        bus2.req = 2'b00;
        n_checks++; if (bus2.err !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", bus2.err); end
        n_checks++; if (bus2.wait_vec !== 2'b01) begin n_fail++; $display("FAIL sat_wv: got %b want 01", bus2.wait_vec); end
        // Three responses drain a counter clamped at 3; a wrapped counter would not match.
        bus2.resp = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b0) begin n_fail++; $display("FAIL sat_adv3: got %b want 0", bus2.advance); end
        repeat (2) tick();
        @(negedge clk);
        n_checks++; if (bus2.advance !== 1'b1) begin n_fail++; $display("FAIL sat_adv1: got %b want 1", bus2.advance); end
        tick();
        bus2.resp = 2'b00;
        n_checks++; if (bus2.wait_vec !== 2'b00) begin n_fail++; $display("FAIL sat_wv_end: got %b want 00", bus2.wait_vec); end
        n_checks++; if (bus2.state !== 2'b01) begin n_fail++; $display("FAIL sat_state: got %b want 01", bus2.state); end
        repeat (3) tick();
        n_checks++; if (bus2.err !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b want 1", bus2.err); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus2.req   = '0;
        bus2.resp  = '0;
        bus2.flush = 1'b0;
        bus4.req   = '0;
        bus4.resp  = '0;
        bus4.flush = 1'b0;

        test_reset();
        test_stall_release();
        test_flush();
        test_same_cycle_4port();
        test_reset_mid();
        test_idle_resp();
        test_saturate();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of memory channels (port 0 = imem, port 1 = dmem, others general).
REQ-002 SHALL have parameter CNT_W, default 2, outstanding-counter width per port; maximum outstanding MAXO = 2**CNT_W-1.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_PORTS  per-port request issued this cycle.
REQ-006 SHALL have port resp  input  NUM_PORTS  per-port response returned this cycle.
REQ-007 SHALL have port flush  input  1  pipeline redirect; in-flight responses become stale.
REQ-008 SHALL have port advance  output  1  pipeline stage registers may update this cycle.
REQ-009 SHALL have port resp_ok  output  NUM_PORTS  response accepted as live (not stale).
REQ-010 SHALL have port wait_vec  output  NUM_PORTS  port has live outstanding requests (registered count nonzero).
REQ-011 SHALL have port state  output  2  current FSM state: IDLE=2'b00, MOVING=2'b01, WAIT=2'b10, DRAIN=2'b11.
REQ-012 SHALL have port err  output  1  sticky protocol error.

Function
REQ-013 SHALL keep per port a live counter pend[i] (CNT_W bits) and a stale counter stale[i] (CNT_W+1 bits).
REQ-014 resp_ok[i] SHALL be combinational: resp[i] AND stale[i]==0.
REQ-015 A resp with stale[i]>0 SHALL decrement stale[i] and SHALL NOT change pend[i].
REQ-016 Without flush: pend[i] next = pend[i] + req[i] - resp_ok[i]; req and resp_ok in the same cycle leave it unchanged.
REQ-017 With flush: stale[i] next = stale[i] + pend[i] - resp[i]; pend[i] next = req[i] (a request in the flush cycle is live).
REQ-018 Increment at pend[i]==MAXO SHALL saturate at MAXO and set err.
REQ-019 Stale increment beyond 2*MAXO SHALL saturate at 2*MAXO and set err.
REQ-020 resp[i] with stale[i]==0 and pend[i]==0 SHALL set err and leave both counters at 0.
REQ-021 err SHALL stay 1 until rst.
REQ-022 advance SHALL be combinational: 0 in IDLE.
REQ-023 advance SHALL be 1 when flush=1 and state is not IDLE.
REQ-024 Otherwise advance SHALL be 1 iff every port has pend[i]==0, or pend[i]==1 with resp_ok[i]=1.
REQ-025 Stale counts SHALL NOT block advance.
REQ-026 FSM: IDLE SHALL go to MOVING unconditionally on the next edge (one dead cycle after reset).
REQ-027 From any non-IDLE state, next state SHALL be WAIT if any next pend is nonzero, else DRAIN if any next stale is nonzero, else MOVING.
REQ-028 wait_vec[i] SHALL equal (pend[i]!=0) from registered values.
REQ-029 Ports SHALL be fully independent; simultaneous events on different ports SHALL all be applied in the same cycle.
REQ-030 Any NUM_PORTS>=1 and CNT_W>=1 SHALL be supported without RTL edits.

Reset
REQ-031 On rst assertion, independent of clk: all counters 0, state=IDLE, err=0, advance=0, wait_vec=0.
REQ-032 resp_ok SHALL follow REQ-014 with stale=0 during reset.
REQ-033 Reset mid-operation SHALL discard all live and stale counts; responses after reset release are counted as errors per REQ-020.

Verification
REQ-034 Reset release, idle inputs -> state IDLE one cycle, advance=0, then MOVING, advance=1.
REQ-035 req=2'b11, then resp=2'b01 next cycle, then resp=2'b10 -> advance 0 then 1; state WAIT,WAIT then MOVING.
REQ-036 Port 1 pend=1, flush with req=2'b01 -> advance=1; next: stale[1]=1, pend[0]=1, state WAIT; later resp=2'b10 -> resp_ok=2'b00, stale[1]=0.
REQ-037 CNT_W=2, four req on port 0 with no resp -> pend saturates at 3, err=1 and stays 1.
REQ-038 resp on idle port -> err=1, resp_ok=1, counters remain 0.
REQ-039 NUM_PORTS=4: req and resp on the same port same cycle -> pend unchanged, advance unaffected.
